// File: rtl/mtm_alu_frame_rx.sv
// mtm_alu_frame_rx
// Serial frame receiver for the ALU datapath. Each clock, one bit is
// sampled from `sin`. The bits form 11-bit packets:
//   start(0), type(0=data,1=cmd), 8 payload bits MSB first, stop(1).
// A frame is BPF = NUM_OPS*DATA_W/8 data packets, followed by one command
// packet with payload {1'b0, opcode[2:0], crc[3:0]}.
// The receiver checks byte count, CRC-4 (x^4+x+1) and stop bits. It then
// loads a report into a single holding register, which the core reads
// over a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   sin          serial input, idle high
//   out_ready    core accepts the held report when high with out_valid
//   out_valid    report available in the holding register
//   out_operands operands, operand 0 in the MSBs (0 on error reports)
//   out_opcode   received opcode (0 on framing errors)
//   out_err      bit0 count/order error, bit1 CRC error, bit2 stop-bit error
//   overflow     one-cycle pulse when a report is dropped because the
//                holding register is still occupied
module mtm_alu_frame_rx #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int CRC_EN  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sin,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [NUM_OPS*DATA_W-1:0]   out_operands,
    output logic [2:0]                  out_opcode,
    output logic [2:0]                  out_err,
    output logic                        overflow
);

    localparam int OPS_W = NUM_OPS * DATA_W;
    localparam int BPF   = OPS_W / 8;
    localparam int CNT_W = $clog2(BPF + 2);

    localparam logic [CNT_W-1:0] BPF_C     = CNT_W'(BPF);
    localparam logic [CNT_W-1:0] CNT_SAT_C = CNT_W'(BPF + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TYPE    = 3'd1;
    localparam logic [2:0] S_PAYLOAD = 3'd2;
    localparam logic [2:0] S_STOP    = 3'd3;
    localparam logic [2:0] S_RESYNC  = 3'd4;

    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
        crc_step = {c[2:0], 1'b0} ^ ((c[3] ^ b) ? 4'b0011 : 4'b0000);
    endfunction

    logic [2:0]       r_state;
    logic [2:0]       r_bitcnt;
    logic             r_type;
    logic [7:0]       r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_crc;
    logic [OPS_W-1:0] r_data;

    logic             r_valid;
    logic [OPS_W-1:0] r_ops;
    logic [2:0]       r_opc;
    logic [2:0]       r_err;
    logic             r_ovf;

    logic             w_good_stop;
    logic             w_bad_stop;
    logic             w_cmd_done;
    logic             w_data_done;
    logic             w_rep;
    logic             w_accept;
    logic [2:0]       w_opc;
    logic [3:0]       w_crc_rx;
    logic [3:0]       w_crc_a;
    logic [3:0]       w_crc_b;
    logic [3:0]       w_crc_c;
    logic [3:0]       w_crc_final;
    logic [OPS_W-1:0] w_rep_ops;
    logic [2:0]       w_rep_opc;
    logic [2:0]       w_rep_err;

    assign w_good_stop = (r_state == S_STOP) && sin;
    assign w_bad_stop  = (r_state == S_STOP) && !sin;
    assign w_cmd_done  = w_good_stop && r_type;
    assign w_data_done = w_good_stop && !r_type;
    assign w_rep       = w_cmd_done || w_bad_stop;
    assign w_accept    = r_valid && out_ready;

    assign w_opc    = r_shift[6:4];
    assign w_crc_rx = r_shift[3:0];

    // The CRC closes over the marker bit 1 and then the opcode. Both are
    // known only once the command payload is complete, so the last four
    // steps are unrolled combinationally here.
    assign w_crc_a     = crc_step(r_crc, 1'b1);
    assign w_crc_b     = crc_step(w_crc_a, w_opc[2]);
    assign w_crc_c     = crc_step(w_crc_b, w_opc[1]);
    assign w_crc_final = crc_step(w_crc_c, w_opc[0]);

    always_comb begin
        w_rep_ops = '0;
        w_rep_opc = '0;
        w_rep_err = 3'b000;
        if (w_bad_stop) begin
            w_rep_err = 3'b100;
        end else if (r_cnt != BPF_C) begin
            w_rep_err = 3'b001;
            w_rep_opc = w_opc;
        end else if ((CRC_EN != 0) && (w_crc_final != w_crc_rx)) begin
            w_rep_err = 3'b010;
            w_rep_opc = w_opc;
        end else begin
            w_rep_ops = r_data;
            w_rep_opc = w_opc;
        end
    end

    // Receive FSM and frame accumulation; never stalls on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_bitcnt <= '0;
            r_type   <= 1'b0;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_crc    <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!sin) r_state <= S_TYPE;
                end
                S_TYPE: begin
                    r_type   <= sin;
                    r_bitcnt <= '0;
                    r_state  <= S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    r_shift  <= {r_shift[6:0], sin};
                    r_bitcnt <= r_bitcnt + 3'd1;
                    if (!r_type) r_crc <= crc_step(r_crc, sin);
                    if (r_bitcnt == 3'd7) r_state <= S_STOP;
                end
                S_STOP: begin
                    r_state <= sin ? S_IDLE : S_RESYNC;
                end
                S_RESYNC: begin
                    if (sin) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_data_done) begin
                r_data <= (r_data << 8) | OPS_W'(r_shift);
                if (r_cnt != CNT_SAT_C) r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_rep) begin
                r_cnt <= '0;
                r_crc <= '0;
            end
        end
    end

    // Holding register. If the held report is accepted in the same cycle
    // as a new one arrives, the new report replaces it without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ops   <= '0;
            r_opc   <= '0;
            r_err   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= w_rep && r_valid && !out_ready;
            if (w_rep && (!r_valid || w_accept)) begin
                r_valid <= 1'b1;
                r_ops   <= w_rep_ops;
                r_opc   <= w_rep_opc;
                r_err   <= w_rep_err;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_operands = r_ops;
    assign out_opcode   = r_opc;
    assign out_err      = r_err;
    assign overflow     = r_ovf;

endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
// Scoreboard bench for mtm_alu_frame_rx. Two instances share the stimulus:
// dut1 has CRC checking enabled, dut2 has it disabled.
module tb_mtm_alu_frame_rx;

    localparam int DATA_W  = 32;
    localparam int NUM_OPS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic        out_ready;

    logic        v1, v2;
    logic [63:0] ops1, ops2;
    logic [2:0]  opc1, opc2, err1, err2;
    logic        ovf1, ovf2;

    always #5 clk = ~clk;

    mtm_alu_frame_rx #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .CRC_EN(1)) dut1 (
        .clk(clk), .rst(rst), .sin(sin), .out_ready(out_ready),
        .out_valid(v1), .out_operands(ops1), .out_opcode(opc1),
        .out_err(err1), .overflow(ovf1)
    );

    mtm_alu_frame_rx #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .CRC_EN(0)) dut2 (
        .clk(clk), .rst(rst), .sin(sin), .out_ready(out_ready),
        .out_valid(v2), .out_operands(ops2), .out_opcode(opc2),
        .out_err(err2), .overflow(ovf2)
    );

    typedef struct packed {
        logic [63:0] ops;
        logic [2:0]  opc;
        logic [2:0]  err;
    } rep_t;

    rep_t q1[$];
    rep_t q2[$];
    int   checks    = 0;
    int   errors    = 0;
    int   ovf_exp   = 0;
    int   ovf_seen1 = 0;
    int   ovf_seen2 = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rep_t mk(input logic [63:0] data, input logic [2:0] opc,
                                input logic [2:0] err);
        rep_t r;
        if (err == 3'b100)      r = '{ops: 64'd0, opc: 3'd0, err: err};
        else if (err != 3'b000) r = '{ops: 64'd0, opc: opc, err: err};
        else                    r = '{ops: data, opc: opc, err: 3'b000};
        return r;
    endfunction

    // err is the dut1 (CRC on) result; dut2 never reports a CRC error.
    task automatic expect_frame(input logic [63:0] data, input logic [2:0] opc,
                                input logic [2:0] err);
        q1.push_back(mk(data, opc, err));
        q2.push_back(mk(data, opc, (err == 3'b010) ? 3'b000 : err));
    endtask

    function automatic logic [3:0] crc_of(input logic [63:0] data, input logic [2:0] opc);
        logic [3:0]  c;
        logic [67:0] bits;
        logic        fb;
        c    = 4'd0;
        bits = {data, 1'b1, opc};
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ bits[i];
            c  = {c[2:0], 1'b0};
            if (fb) c = c ^ 4'b0011;
        end
        return c;
    endfunction

    task automatic bit_out(input logic b);
        sin = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic typ, input logic [7:0] pl, input logic stop,
                            input logic rdy_at_stop);
        bit_out(1'b0);
        bit_out(typ);
        for (int i = 7; i >= 0; i--) bit_out(pl[i]);
        if (rdy_at_stop) out_ready = 1'b1;
        bit_out(stop);
        sin = 1'b1;
    endtask

    task automatic send_frame(input logic [63:0] data, input int nbytes,
                              input logic [7:0] cmd, input logic rdy_at_stop);
        logic [7:0] b;
        for (int i = 0; i < nbytes; i++) begin
            b = (i < 8) ? 8'(data >> (8 * (7 - i))) : 8'h00;
            send_pkt(1'b0, b, 1'b1, 1'b0);
        end
        send_pkt(1'b1, cmd, 1'b1, rdy_at_stop);
    endtask

    // Monitors: one transfer per cycle with out_valid && out_ready.
    always @(negedge clk) begin
        rep_t e;
        if (!rst) begin
            if (v1 && out_ready) begin
                if (q1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut1 unexpected report: got err %b opc %0d, required none", err1, opc1);
                end else begin
                    e = q1.pop_front();
                    check("dut1 operands", ops1, e.ops);
                    check("dut1 opcode", 64'(opc1), 64'(e.opc));
                    check("dut1 err", 64'(err1), 64'(e.err));
                end
            end
            if (ovf1) ovf_seen1++;
        end
    end

    always @(negedge clk) begin
        rep_t e;
        if (!rst) begin
            if (v2 && out_ready) begin
                if (q2.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dut2 unexpected report: got err %b opc %0d, required none", err2, opc2);
                end else begin
                    e = q2.pop_front();
                    check("dut2 operands", ops2, e.ops);
                    check("dut2 opcode", 64'(opc2), 64'(e.opc));
                    check("dut2 err", 64'(err2), 64'(e.err));
                end
            end
            if (ovf2) ovf_seen2++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [63:0] da, db, dc, dd, de;
        logic [2:0]  oa, ob, oc, od, oe;

        rst = 1'b1; sin = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(v1), 64'd0);
        check("reset operands", ops1, 64'd0);
        check("reset opcode", 64'(opc1), 64'd0);
        check("reset err", 64'(err1), 64'd0);
        check("reset overflow", 64'(ovf1), 64'd0);
        check("reset dut2 out_valid", 64'(v2), 64'd0);
        rst = 1'b0;
        idle(3);
        out_ready = 1'b1;

        // Zero frame with the CRC 0xB worked out by hand.
        expect_frame(64'd0, 3'd0, 3'b000);
        send_frame(64'd0, 8, 8'h0B, 1'b0);
        check("s1 valid 1 clk after stop", 64'(v1), 64'd1);
        check("s1 dut2 valid", 64'(v2), 64'd1);
        idle(5);

        // Wrong CRC: dut1 reports it, dut2 ignores it.
        expect_frame(64'd0, 3'd0, 3'b010);
        send_frame(64'd0, 8, 8'h0A, 1'b0);
        idle(5);

        // Short and long frames.
        expect_frame(64'd0, 3'd0, 3'b001);
        send_frame(64'd0, 7, 8'h0B, 1'b0);
        idle(5);
        expect_frame(64'd0, 3'b101, 3'b001);
        send_frame(64'd0, 9, 8'h5B, 1'b0);
        idle(5);

        // Non-zero data with the CRC from the bench model.
        da = 64'h0123_4567_89AB_CDEF; oa = 3'd3;
        expect_frame(da, oa, 3'b000);
        send_frame(da, 8, {1'b0, oa, crc_of(da, oa)}, 1'b0);
        idle(5);

        // Bad stop bit mid-frame, then resync and a clean frame.
        expect_frame(64'd0, 3'd0, 3'b100);
        send_pkt(1'b0, 8'h11, 1'b1, 1'b0);
        send_pkt(1'b0, 8'h22, 1'b1, 1'b0);
        send_pkt(1'b0, 8'h33, 1'b1, 1'b0);
        send_pkt(1'b0, 8'h44, 1'b0, 1'b0);
        repeat (5) bit_out(1'b0);
        idle(3);
        expect_frame(64'd0, 3'd0, 3'b000);
        send_frame(64'd0, 8, 8'h0B, 1'b0);
        idle(5);

        // Overflow: a second report arrives while the first is held.
        out_ready = 1'b0;
        da = 64'hDEAD_BEEF_CAFE_F00D; oa = 3'd6;
        db = 64'h0011_2233_4455_6677; ob = 3'd1;
        expect_frame(da, oa, 3'b000);
        send_frame(da, 8, {1'b0, oa, crc_of(da, oa)}, 1'b0);
        check("s5 first held valid", 64'(v1), 64'd1);
        idle(3);
        send_frame(db, 8, {1'b0, ob, crc_of(db, ob)}, 1'b0);
        ovf_exp++;
        check("s5 overflow pulse", 64'(ovf1), 64'd1);
        check("s5 dut2 overflow pulse", 64'(ovf2), 64'd1);
        check("s5 held operands", ops1, da);
        check("s5 held opcode", 64'(opc1), 64'(oa));
        idle(1);
        check("s5 overflow one cycle", 64'(ovf1), 64'd0);
        out_ready = 1'b1;
        idle(5);

        // Replacement: the held report is taken in the same cycle the next one loads.
        out_ready = 1'b0;
        dc = 64'h8000_0000_0000_0001; oc = 3'd7;
        dd = 64'h5555_AAAA_5555_AAAA; od = 3'd2;
        expect_frame(dc, oc, 3'b000);
        send_frame(dc, 8, {1'b0, oc, crc_of(dc, oc)}, 1'b0);
        idle(3);
        expect_frame(dd, od, 3'b000);
        send_frame(dd, 8, {1'b0, od, crc_of(dd, od)}, 1'b1);
        check("s5 replace no overflow", 64'(ovf1), 64'd0);
        check("s5 replace valid", 64'(v1), 64'd1);
        check("s5 replace operands", ops1, dd);
        idle(5);

        // Reset mid-frame clears a held, unaccepted report.
        out_ready = 1'b0;
        de = 64'hFFFF_0000_1234_5678; oe = 3'd4;
        send_frame(de, 8, {1'b0, oe, crc_of(de, oe)}, 1'b0);
        check("s6 held before reset", 64'(v1), 64'd1);
        idle(2);
        send_pkt(1'b0, 8'hA1, 1'b1, 1'b0);
        send_pkt(1'b0, 8'hA2, 1'b1, 1'b0);
        send_pkt(1'b0, 8'hA3, 1'b1, 1'b0);
        bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
        #2 rst = 1'b1;
        #1;
        check("s6 rst out_valid", 64'(v1), 64'd0);
        check("s6 rst operands", ops1, 64'd0);
        check("s6 rst opcode", 64'(opc1), 64'd0);
        check("s6 rst err", 64'(err1), 64'd0);
        check("s6 rst overflow", 64'(ovf1), 64'd0);
        check("s6 rst dut2 out_valid", 64'(v2), 64'd0);
        check("s6 rst dut2 operands", ops2, 64'd0);
        sin = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        idle(5);
        expect_frame(64'd0, 3'd0, 3'b000);
        send_frame(64'd0, 8, 8'h0B, 1'b0);
        idle(5);

        for (int i = 0; i < 100; i++) begin
            if (q1.size() == 0 && q2.size() == 0) break;
            idle(1);
        end
        check("dut1 pending reports", 64'(q1.size()), 64'd0);
        check("dut2 pending reports", 64'(q2.size()), 64'd0);
        check("dut1 overflow count", 64'(ovf_seen1), 64'(ovf_exp));
        check("dut2 overflow count", 64'(ovf_seen2), 64'(ovf_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
